// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's data-memory port (request, write data, grant, read/error response).
interface dmem_arbiter_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic gnt;
  logic rvalid;
  logic [31:0] rdata;
  logic err;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin data-memory arbiter, 1-cycle read latency, contention counter.
// Define DMEM_ARB_BOUNDS_CHECK_EN to block accesses above MEM_MAX and report them on mN_err.
module dmem_arbiter #(
  parameter int unsigned MEM_MAX = 10000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    m0,
  dmem_arbiter_if.slave    m1,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [CNT_W-1:0] conflict_cnt
);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  logic last_q, last_d;
  logic pend_rd_q, pend_rd_d;
  logic pend_err_q, pend_err_d;
  logic pend_id_q, pend_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic gnt0, gnt1, acc, sel, we, oob;
  logic [31:0] addr, wdata;
  // last_q names the requester granted most recently; the other one wins the next contention
  always_comb begin
    gnt0 = !reset && m0.req && (!m1.req || last_q);
    gnt1 = !reset && m1.req && (!m0.req || !last_q);
    acc = gnt0 || gnt1;
    sel = gnt1;
    we = sel ? m1.we : m0.we;
    addr = sel ? m1.addr : m0.addr;
    wdata = sel ? m1.wdata : m0.wdata;
    oob = BOUNDS && acc && (addr > MEM_MAX);
    last_d = acc ? sel : last_q;
    pend_rd_d = acc && !we;
    pend_err_d = oob;
    pend_id_d = sel;
    cnt_d = (m0.req && m1.req && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
      pend_rd_q <= 1'b0;
      pend_err_q <= 1'b0;
      pend_id_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      last_q <= last_d;
      pend_rd_q <= pend_rd_d;
      pend_err_q <= pend_err_d;
      pend_id_q <= pend_id_d;
      cnt_q <= cnt_d;
    end
  end
  assign mem_we = acc && we && !oob;
  assign mem_addr = (acc && !oob) ? addr : 32'd0;
  assign mem_wd = acc ? wdata : 32'd0;
  assign conflict_cnt = cnt_q;
  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;
  // responses are masked during reset so a read accepted just before reset never surfaces
  assign m0.rvalid = !reset && pend_rd_q && !pend_id_q;
  assign m1.rvalid = !reset && pend_rd_q && pend_id_q;
  assign m0.rdata = (m0.rvalid && !pend_err_q) ? mem_rd : 32'd0;
  assign m1.rdata = (m1.rvalid && !pend_err_q) ? mem_rd : 32'd0;
  assign m0.err = !reset && pend_err_q && !pend_id_q;
  assign m1.err = !reset && pend_err_q && pend_id_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int MEM_MAX = 10000;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] q_req = '0;
  logic [1:0] q_we = '0;
  logic [31:0] q_addr [2];
  logic [31:0] q_wd [2];
  logic mem_we, n_mem_we;
  logic [31:0] mem_addr, mem_wd, n_mem_addr, n_mem_wd;
  logic [31:0] mem_rd;
  logic [15:0] conflict_cnt;
  logic [1:0] n_cnt;
  logic [31:0] dev [64];
  int n_cmp = 0;
  int n_bad = 0;
  logic g0, g1, sel_m, acc_c, oob_c, w_c, pv, pid, prd, perr, last_m;
  logic [31:0] a_c, d_c, pdata;
  logic [31:0] mmem [64];
  logic [1:0] acc_m = '0;
  int cnt_m, w0, w1;

  dmem_arbiter_if m0 ();
  dmem_arbiter_if m1 ();
  dmem_arbiter_if n0 ();
  dmem_arbiter_if n1 ();
  assign m0.req = q_req[0];
  assign m0.we = q_we[0];
  assign m0.addr = q_addr[0];
  assign m0.wdata = q_wd[0];
  assign m1.req = q_req[1];
  assign m1.we = q_we[1];
  assign m1.addr = q_addr[1];
  assign m1.wdata = q_wd[1];
  assign n0.req = q_req[0];
  assign n0.we = q_we[0];
  assign n0.addr = q_addr[0];
  assign n0.wdata = q_wd[0];
  assign n1.req = q_req[1];
  assign n1.we = q_we[1];
  assign n1.addr = q_addr[1];
  assign n1.wdata = q_wd[1];

  dmem_arbiter #(.MEM_MAX(MEM_MAX), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .m0(m0), .m1(m1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .conflict_cnt(conflict_cnt)
  );
  dmem_arbiter #(.MEM_MAX(MEM_MAX), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .m0(n0), .m1(n1),
    .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wd(n_mem_wd), .mem_rd(mem_rd),
    .conflict_cnt(n_cnt)
  );

  always #5 clk = ~clk;

  // data memory: synchronous read, data valid the cycle after the address
  always @(posedge clk) begin
    if (mem_we) dev[mem_addr[5:0]] <= mem_wd;
    mem_rd <= dev[mem_addr[5:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model: who wins, what reaches memory, what comes back next cycle
  always @(negedge clk) begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (q_req[0] && q_req[1]) begin
        g1 = (last_m == 1'b0);
        g0 = !g1;
      end else begin
        g0 = q_req[0];
        g1 = q_req[1];
      end
    end
    acc_c = g0 || g1;
    sel_m = g1;
    a_c = q_addr[sel_m];
    d_c = q_wd[sel_m];
    w_c = q_we[sel_m];
    oob_c = acc_c && BC && (a_c > MEM_MAX);
    chk("m0_gnt", {31'd0, m0.gnt}, {31'd0, g0});
    chk("m1_gnt", {31'd0, m1.gnt}, {31'd0, g1});
    chk("mem_we", {31'd0, mem_we}, {31'd0, acc_c && w_c && !oob_c});
    chk("mem_addr", mem_addr, (acc_c && !oob_c) ? a_c : 32'd0);
    chk("mem_wd", mem_wd, acc_c ? d_c : 32'd0);
    chk("m0_rvalid", {31'd0, m0.rvalid}, {31'd0, !reset && pv && prd && !pid});
    chk("m1_rvalid", {31'd0, m1.rvalid}, {31'd0, !reset && pv && prd && pid});
    chk("m0_rdata", m0.rdata, (!reset && pv && prd && !pid) ? pdata : 32'd0);
    chk("m1_rdata", m1.rdata, (!reset && pv && prd && pid) ? pdata : 32'd0);
    chk("m0_err", {31'd0, m0.err}, {31'd0, !reset && pv && perr && !pid});
    chk("m1_err", {31'd0, m1.err}, {31'd0, !reset && pv && perr && pid});
    if (!reset) begin
      chk("conflict_cnt", {16'd0, conflict_cnt}, (cnt_m > 65535) ? 32'd65535 : 32'(cnt_m));
      chk("conflict_cnt_w2", {30'd0, n_cnt}, (cnt_m > 3) ? 32'd3 : 32'(cnt_m));
    end
    if (reset) begin
      pv = 1'b0;
      last_m = 1'b1;
      cnt_m = 0;
      w0 = 0;
      w1 = 0;
    end else begin
      if (q_req[0] && q_req[1]) cnt_m++;
      pv = acc_c;
      pid = sel_m;
      prd = acc_c && !w_c;
      perr = oob_c;
      pdata = oob_c ? 32'd0 : mmem[a_c[5:0]];
      if (acc_c && w_c && !oob_c) mmem[a_c[5:0]] = d_c;
      if (acc_c) last_m = sel_m;
      w0 = (q_req[0] && !m0.gnt) ? w0 + 1 : 0;
      w1 = (q_req[1] && !m1.gnt) ? w1 + 1 : 0;
      chk("wait_bound_m0", 32'(w0 > 1), 32'd0);
      chk("wait_bound_m1", 32'(w1 > 1), 32'd0);
    end
    acc_m = {g1, g0};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input int i, input logic rq, input logic we, input logic [31:0] ad, input logic [31:0] wd);
    q_req[i] = rq;
    q_we[i] = we;
    q_addr[i] = ad;
    q_wd[i] = wd;
  endtask

  task automatic rst();
    reset = 1'b1;
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      dev[i] = 32'hCAFE0000 + 32'(i);
      mmem[i] = 32'hCAFE0000 + 32'(i);
    end
    pv = 1'b0;
    last_m = 1'b1;
    cnt_m = 0;
    w0 = 0;
    w1 = 0;
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
    repeat (2) cyc();
    reset = 1'b0;
    // single read, one-cycle latency
    set(0, 1, 0, 5, 0);
    #1 chk("lit_rd5_gnt", {31'd0, m0.gnt}, 32'd1);
    chk("lit_rd5_addr", mem_addr, 32'd5);
    cyc();
    set(0, 0, 0, 0, 0);
    #1 chk("lit_rd5_rvalid", {31'd0, m0.rvalid}, 32'd1);
    chk("lit_rd5_rdata", m0.rdata, 32'hCAFE0005);
    // contention: m0 first after reset, then alternate
    rst();
    set(0, 1, 1, 20, 32'hA0);
    set(1, 1, 1, 21, 32'hB1);
    #1 chk("lit_rr_c1", {30'd0, m1.gnt, m0.gnt}, 32'b01);
    cyc();
    set(0, 1, 1, 22, 32'hA2);
    #1 chk("lit_rr_c2", {30'd0, m1.gnt, m0.gnt}, 32'b10);
    cyc();
    set(1, 1, 1, 23, 32'hB3);
    #1 chk("lit_rr_c3", {30'd0, m1.gnt, m0.gnt}, 32'b01);
    cyc();
    set(0, 0, 0, 0, 0);
    #1 chk("lit_rr_c4", {30'd0, m1.gnt, m0.gnt}, 32'b10);
    chk("lit_rr_cnt", {16'd0, conflict_cnt}, 32'd3);
    cyc();
    set(1, 0, 0, 0, 0);
    #1 chk("lit_rr_cnt_hold", {16'd0, conflict_cnt}, 32'd3);
    // back-to-back reads to different requesters
    set(0, 1, 0, 1, 0);
    #1 chk("lit_b2b_g0", {31'd0, m0.gnt}, 32'd1);
    cyc();
    set(0, 0, 0, 0, 0);
    set(1, 1, 0, 2, 0);
    #1 chk("lit_b2b_rv0", {31'd0, m0.rvalid}, 32'd1);
    chk("lit_b2b_rd0", m0.rdata, 32'hCAFE0001);
    chk("lit_b2b_g1", {31'd0, m1.gnt}, 32'd1);
    cyc();
    set(1, 0, 0, 0, 0);
    #1 chk("lit_b2b_rv1", {31'd0, m1.rvalid}, 32'd1);
    chk("lit_b2b_rd1", m1.rdata, 32'hCAFE0002);
    // read accepted right before reset is dropped
    set(1, 1, 0, 3, 0);
    #1 chk("lit_rstrd_g1", {31'd0, m1.gnt}, 32'd1);
    cyc();
    set(1, 0, 0, 0, 0);
    reset = 1'b1;
    #1 chk("lit_rstrd_rv_a", {31'd0, m1.rvalid}, 32'd0);
    cyc();
    reset = 1'b0;
    #1 chk("lit_rstrd_rv_b", {31'd0, m1.rvalid}, 32'd0);
    // out-of-range write
    set(0, 1, 1, 10001, 32'h1234);
    #1 chk("lit_oob_we", {31'd0, mem_we}, BC ? 32'd0 : 32'd1);
    chk("lit_oob_addr", mem_addr, BC ? 32'd0 : 32'd10001);
    cyc();
    set(0, 0, 0, 0, 0);
    #1 chk("lit_oob_err", {31'd0, m0.err}, BC ? 32'd1 : 32'd0);
    chk("lit_oob_rv", {31'd0, m0.rvalid}, 32'd0);
    // saturation of the narrow counter
    rst();
    set(0, 1, 1, 30, 32'h30);
    set(1, 1, 1, 31, 32'h31);
    repeat (6) cyc();
    #1 chk("lit_sat_w2", {30'd0, n_cnt}, 32'd3);
    chk("lit_sat_w16", {16'd0, conflict_cnt}, 32'd6);
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
    cyc();
    // randomized traffic; a requester holds its transfer until the model saw it accepted
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!q_req[i] || acc_m[i]) begin
          q_req[i] = ($urandom_range(0, 9) < 7);
          q_we[i] = 1'($urandom_range(0, 1));
          q_addr[i] = ($urandom_range(0, 15) == 0) ? 32'(MEM_MAX + 1 + int'($urandom_range(0, 3))) : 32'($urandom_range(0, 15));
          q_wd[i] = $urandom;
        end
      end
      cyc();
    end
    reset = 1'b0;
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
